// File: rtl/hand_dealer_if.sv
// hand_dealer_if: deal request / card output bundle between a hand controller and hand_dealer.
//   deal_req, new_hand    : controller -> dealer, level-sampled every clock edge
//   card1..card3          : slot card codes, 0 = empty slot
//   num_cards, full       : count of filled slots (0..3) and its "== 3" flag
//   score                 : baccarat hand value 0..9
//   deal_ack, deal_err    : one-cycle pulses reporting the outcome of the previous edge's request
interface hand_dealer_if;
    logic       deal_req;
    logic       new_hand;
    logic [3:0] card1;
    logic [3:0] card2;
    logic [3:0] card3;
    logic [1:0] num_cards;
    logic       full;
    logic [3:0] score;
    logic       deal_ack;
    logic       deal_err;

    modport master (
        output deal_req,
        output new_hand,
        input  card1,
        input  card2,
        input  card3,
        input  num_cards,
        input  full,
        input  score,
        input  deal_ack,
        input  deal_err
    );

    modport slave (
        input  deal_req,
        input  new_hand,
        output card1,
        output card2,
        output card3,
        output num_cards,
        output full,
        output score,
        output deal_ack,
        output deal_err
    );
endinterface

// File: rtl/hand_dealer.sv
// hand_dealer: deals pseudo-random cards into a three-slot baccarat hand.
// A free-running counter cycling 1..MAX_CARD acts as the deck; a deal request captures the
// counter value into the next free slot. Empty slots read as code 0 so the downstream
// 7-segment decoder blanks them.
//   clk    : system clock, all state changes on the rising edge
//   reset  : synchronous, active-high; clears the hand and restarts the counter at 1
//   bus    : hand_dealer_if.slave (requests in, cards/count/score/status out)
module hand_dealer #(
    parameter int unsigned MAX_CARD = 13
) (
    input  logic          clk,
    input  logic          reset,
    hand_dealer_if.slave  bus
);

    localparam logic [3:0] MaxCode = 4'(MAX_CARD);

    logic [3:0] counter_q, counter_d;
    logic [3:0] card1_q, card1_d;
    logic [3:0] card2_q, card2_d;
    logic [3:0] card3_q, card3_d;
    logic [1:0] num_q, num_d;
    logic       ack_q, ack_d;
    logic       err_q, err_d;
    logic       full;

    // Baccarat point value: aces count 1, 2..9 face value, tens and courts (and blank) 0.
    function automatic logic [3:0] card_value(input logic [3:0] code);
        if (code <= 4'd9) begin
            return code;
        end
        return 4'd0;
    endfunction

    assign full = (num_q == 2'd3);

    // Deck counter: wraps MAX_CARD -> 1 so it never presents 0 (the blank code).
    always_comb begin
        counter_d = 4'd1;
        if (counter_q < MaxCode) begin
            counter_d = counter_q + 4'd1;
        end
    end

    // Hand slots. new_hand wins over deal_req; a deal while full only raises deal_err.
    always_comb begin
        card1_d = card1_q;
        card2_d = card2_q;
        card3_d = card3_q;
        num_d   = num_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        if (bus.new_hand) begin
            card1_d = 4'd0;
            card2_d = 4'd0;
            card3_d = 4'd0;
            num_d   = 2'd0;
        end else if (bus.deal_req) begin
            if (full) begin
                err_d = 1'b1;
            end else begin
                unique case (num_q)
                    2'd0:    card1_d = counter_q;
                    2'd1:    card2_d = counter_q;
                    default: card3_d = counter_q;
                endcase
                num_d = num_q + 2'd1;
                ack_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            counter_q <= 4'd1;
            card1_q   <= 4'd0;
            card2_q   <= 4'd0;
            card3_q   <= 4'd0;
            num_q     <= 2'd0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            counter_q <= counter_d;
            card1_q   <= card1_d;
            card2_q   <= card2_d;
            card3_q   <= card3_d;
            num_q     <= num_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
        end
    end

    // Score is combinational so it tracks a new card in the cycle it appears.
    // Raw sum is at most 27, so two conditional subtractions implement mod 10.
    logic [4:0] sum;
    logic [4:0] sum_mod;

    always_comb begin
        sum = 5'(card_value(card1_q)) + 5'(card_value(card2_q)) + 5'(card_value(card3_q));
        sum_mod = sum;
        if (sum >= 5'd20) begin
            sum_mod = sum - 5'd20;
        end else if (sum >= 5'd10) begin
            sum_mod = sum - 5'd10;
        end
    end

    assign bus.card1     = card1_q;
    assign bus.card2     = card2_q;
    assign bus.card3     = card3_q;
    assign bus.num_cards = num_q;
    assign bus.full      = full;
    assign bus.score     = sum_mod[3:0];
    assign bus.deal_ack  = ack_q;
    assign bus.deal_err  = err_q;

endmodule
